// File: rtl/psg_bus_sequencer.sv
// Bus sequencer for a pair of ym2149 PSGs shared by two requesters.
// Generates address/data/read phases with BDIR-low gaps and a per-chip address cache.
module psg_bus_sequencer #(
  parameter int unsigned PHASE_LEN = 1,
  parameter int unsigned GAP_LEN   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       WE0,
  input  logic       WE1,
  input  logic       CS0,
  input  logic       CS1,
  input  logic [3:0] RA0,
  input  logic [3:0] RA1,
  input  logic [7:0] WD0,
  input  logic [7:0] WD1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] RD,
  output logic       BUSY,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic       PSG_CS,
  output logic [7:0] PSG_DO,
  input  logic [7:0] PSG_DI
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_AGAP, S_DATA, S_DGAP, S_READ, S_ACK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_port;
  logic             r_last;
  logic             r_we;
  logic             r_cs;
  logic [3:0]       r_ra;
  logic [7:0]       r_wd;
  logic             r_cvalid [2];
  logic [3:0]       r_caddr  [2];

  // Round-robin: on a tie the port not granted last time wins
  logic       w_grant1;
  logic       w_we;
  logic       w_cs;
  logic [3:0] w_ra;
  logic [7:0] w_wd;
  logic       w_hit;

  assign w_grant1 = REQ1 & (~REQ0 | ~r_last);
  assign w_we     = w_grant1 ? WE1 : WE0;
  assign w_cs     = w_grant1 ? CS1 : CS0;
  assign w_ra     = w_grant1 ? RA1 : RA0;
  assign w_wd     = w_grant1 ? WD1 : WD0;
  assign w_hit    = r_cvalid[w_cs] && (r_caddr[w_cs] == w_ra);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_port      <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_cs        <= 1'b0;
      r_ra        <= '0;
      r_wd        <= '0;
      r_cvalid[0] <= 1'b0;
      r_cvalid[1] <= 1'b0;
      r_caddr[0]  <= '0;
      r_caddr[1]  <= '0;
      ACK0        <= 1'b0;
      ACK1        <= 1'b0;
      RD          <= '0;
      BUSY        <= 1'b0;
      PSG_BDIR    <= 1'b0;
      PSG_BC      <= 1'b0;
      PSG_CS      <= 1'b0;
      PSG_DO      <= '0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            r_port <= w_grant1;
            r_last <= w_grant1;
            r_we   <= w_we;
            r_cs   <= w_cs;
            r_ra   <= w_ra;
            r_wd   <= w_wd;
            r_cnt  <= '0;
            PSG_CS <= w_cs;
            BUSY   <= 1'b1;
            if (!w_hit) begin
              r_state  <= S_ADDR;
              PSG_BDIR <= 1'b1;
              PSG_BC   <= 1'b1;
              PSG_DO   <= {4'b0000, w_ra};
            end else if (w_we) begin
              r_state  <= S_DATA;
              PSG_BDIR <= 1'b1;
              PSG_BC   <= 1'b0;
              PSG_DO   <= w_wd;
            end else begin
              r_state  <= S_READ;
              PSG_BDIR <= 1'b0;
              PSG_BC   <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (r_cnt == P_LAST) begin
            r_cvalid[r_cs] <= 1'b1;
            r_caddr[r_cs]  <= r_ra;
            r_cnt          <= '0;
            r_state        <= S_AGAP;
            PSG_BDIR       <= 1'b0;
            PSG_BC         <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_AGAP: begin
          if (r_cnt == G_LAST) begin
            r_cnt <= '0;
            if (r_we) begin
              r_state  <= S_DATA;
              PSG_BDIR <= 1'b1;
              PSG_DO   <= r_wd;
            end else begin
              r_state <= S_READ;
              PSG_BC  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == P_LAST) begin
            r_cnt    <= '0;
            r_state  <= S_DGAP;
            PSG_BDIR <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DGAP: begin
          if (r_cnt == G_LAST) begin
            r_state <= S_ACK;
            ACK0    <= ~r_port;
            ACK1    <= r_port;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          if (r_cnt == P_LAST) begin
            RD      <= PSG_DI;
            PSG_BC  <= 1'b0;
            r_state <= S_ACK;
            ACK0    <= ~r_port;
            ACK1    <= r_port;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          BUSY    <= 1'b0;
          PSG_DO  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Scoreboard bench for psg_bus_sequencer: reference model predicts grant order,
// latency and read data; a monitor pops expectations on every ACK.
module tb_psg_bus_sequencer;

  localparam int P  = 1;
  localparam int G  = 1;
  localparam int P2 = 3;
  localparam int G2 = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET;
  logic       req [2];
  logic       we  [2];
  logic       cs  [2];
  logic [3:0] ra  [2];
  logic [7:0] wd  [2];
  logic       ack0, ack1, busy, bdir, bc, pcs;
  logic [7:0] rd, pdo, pdi;

  logic       req2, we2, cs2;
  logic [3:0] ra2;
  logic [7:0] wd2;
  logic       ack2_0, ack2_1, busy2, bdir2, bc2, pcs2;
  logic [7:0] rd2, pdo2;

  psg_bus_sequencer u_dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(req[0]), .REQ1(req[1]), .WE0(we[0]), .WE1(we[1]),
    .CS0(cs[0]), .CS1(cs[1]), .RA0(ra[0]), .RA1(ra[1]),
    .WD0(wd[0]), .WD1(wd[1]), .ACK0(ack0), .ACK1(ack1), .RD(rd),
    .BUSY(busy), .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_CS(pcs),
    .PSG_DO(pdo), .PSG_DI(pdi)
  );

  psg_bus_sequencer #(.PHASE_LEN(P2), .GAP_LEN(G2)) u_dut2 (
    .CLK(CLK), .RESET(RESET),
    .REQ0(req2), .REQ1(1'b0), .WE0(we2), .WE1(1'b0),
    .CS0(cs2), .CS1(1'b0), .RA0(ra2), .RA1(4'h0),
    .WD0(wd2), .WD1(8'h00), .ACK0(ack2_0), .ACK1(ack2_1), .RD(rd2),
    .BUSY(busy2), .PSG_BDIR(bdir2), .PSG_BC(bc2), .PSG_CS(pcs2),
    .PSG_DO(pdo2), .PSG_DI(8'h00)
  );

  // Two-chip PSG bus model
  logic [7:0] psg_regs [2][16];
  logic [3:0] psg_addr [2];
  logic       psg_clr, psg_ld, ld_c;
  logic [3:0] ld_r;
  logic [7:0] ld_v;

  always @(posedge CLK) begin
    if (psg_clr) begin
      for (int c = 0; c < 2; c++) begin
        psg_addr[c] <= 4'h0;
        for (int r = 0; r < 16; r++) psg_regs[c][r] <= 8'h00;
      end
    end else if (psg_ld) psg_regs[ld_c][ld_r] <= ld_v;
    else if (bdir && bc) psg_addr[pcs] <= pdo[3:0];
    else if (bdir && !bc) psg_regs[pcs][psg_addr[pcs]] <= pdo;
  end
  assign pdi = psg_regs[pcs][psg_addr[pcs]];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, exp_v, exp_v);
    end
  endtask

  typedef struct packed {
    logic       bdir, bc, cs, a0, a1, busy;
    logic [7:0] dout;
  } tr_t;
  tr_t tr1 [int];
  tr_t tr2 [int];

  typedef struct {
    int   port;
    bit   we;
    int   rd;
    int   ackc;
  } exp_t;
  exp_t q [$];
  exp_t mon_e;

  // Reference model state
  bit         mc_valid [2];
  logic [3:0] mc_addr  [2];
  int         m_last;
  logic [7:0] ref_regs [2][16];
  int         last_n;

  logic m_bdir = 1'b0, m_busy = 1'b0, m_cs = 1'b0;
  logic [7:0] m_do = 8'h00;

  // Monitor: trace capture, scoreboard pop on ACK, bus stability
  always @(negedge CLK) begin
    tr1[cyc] = '{bdir, bc, pcs, ack0, ack1, busy, pdo};
    tr2[cyc] = '{bdir2, bc2, pcs2, ack2_0, ack2_1, busy2, pdo2};
    if (RESET === 1'b0) begin
      if (ack0 || ack1) begin
        chk("ack_onehot", int'(ack0 && ack1), 0);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL ack_unexpected @cyc %0d: ack0=%0b ack1=%0b, none expected", cyc, ack0, ack1);
        end else begin
          mon_e = q.pop_front();
          chk("ack_port", int'(ack1), mon_e.port);
          chk("ack_cycle", cyc, mon_e.ackc);
          chk("busy_in_ack", int'(busy), 1);
          if (!mon_e.we) chk("rd_data", int'(rd), mon_e.rd);
        end
      end
      if (m_bdir && bdir) chk("do_stable_bdir", int'(pdo), int'(m_do));
      if (m_busy && busy) chk("cs_stable_busy", int'(pcs), int'(m_cs));
    end
    m_bdir = bdir; m_busy = busy; m_cs = pcs; m_do = pdo;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_txn(input int p, input bit w, input bit c, input int a, input int d);
    we[p] = w; cs[p] = c; ra[p] = 4'(a); wd[p] = 8'(d);
  endtask

  task automatic rand_txn(input int p);
    set_txn(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
  endtask

  // Predict the grant taken at the next edge and wait until its ACK cycle
  task automatic grant_one(output int g);
    int n, l;
    logic c;
    logic [3:0] a;
    bit hit;
    exp_t e;
    n = cyc;
    if (req[0] && req[1]) g = (m_last == 1) ? 0 : 1;
    else g = req[0] ? 0 : 1;
    m_last = g;
    c = cs[g];
    a = ra[g];
    hit = mc_valid[c] && (mc_addr[c] == a);
    if (we[g]) l = hit ? P + G + 1 : 2*P + 2*G + 1;
    else       l = hit ? P + 1     : 2*P + G + 1;
    mc_valid[c] = 1'b1;
    mc_addr[c]  = a;
    if (we[g]) ref_regs[c][a] = wd[g];
    e.port = g; e.we = we[g]; e.rd = int'(ref_regs[c][a]); e.ackc = n + l;
    q.push_back(e);
    last_n = n;
    repeat (l) @(posedge CLK);
    #1;
  endtask

  task automatic single(input int p, input bit w, input bit c, input int a, input int d);
    int g;
    set_txn(p, w, c, a, d);
    req[p] = 1'b1;
    grant_one(g);
    req[p] = 1'b0;
    next_cycle();
  endtask

  initial begin
    int g, n;
    RESET = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0;
      set_txn(p, 1'b0, 1'b0, 0, 0);
      mc_valid[p] = 1'b0;
      mc_addr[p] = 4'h0;
      for (int r = 0; r < 16; r++) ref_regs[p][r] = 8'h00;
    end
    req2 = 1'b0; we2 = 1'b0; cs2 = 1'b0; ra2 = 4'h0; wd2 = 8'h00;
    psg_clr = 1'b1; psg_ld = 1'b0; ld_c = 1'b0; ld_r = 4'h0; ld_v = 8'h00;
    m_last = 1;
    repeat (3) next_cycle();
    psg_clr = 1'b0;

    chk("rst_bdir", int'(bdir), 0);
    chk("rst_bc", int'(bc), 0);
    chk("rst_do", int'(pdo), 0);
    chk("rst_cs", int'(pcs), 0);
    chk("rst_ack", int'({ack0, ack1}), 0);
    chk("rst_rd", int'(rd), 0);
    chk("rst_busy", int'(busy), 0);
    RESET = 1'b0;
    next_cycle();

    // Write miss on chip 0, reg 7
    set_txn(0, 1'b1, 1'b0, 7, 8'h38);
    req[0] = 1'b1;
    grant_one(g);
    n = last_n;
    req[0] = 1'b0;
    chk("wm_c1_bdirbc", int'({tr1[n+1].bdir, tr1[n+1].bc}), 3);
    chk("wm_c1_do", int'(tr1[n+1].dout), 8'h07);
    chk("wm_c2_bdirbc", int'({tr1[n+2].bdir, tr1[n+2].bc}), 0);
    chk("wm_c3_bdirbc", int'({tr1[n+3].bdir, tr1[n+3].bc}), 2);
    chk("wm_c3_do", int'(tr1[n+3].dout), 8'h38);
    next_cycle();
    chk("psg_reg7", int'(psg_regs[0][7]), 8'h38);

    // Write hit, then same reg on the other chip (must miss)
    single(0, 1'b1, 1'b0, 7, 8'h3F);
    chk("wh_psg_reg7", int'(psg_regs[0][7]), 8'h3F);
    set_txn(1, 1'b1, 1'b1, 7, 8'h11);
    req[1] = 1'b1;
    grant_one(g);
    n = last_n;
    req[1] = 1'b0;
    chk("c1_addr_phase", int'({tr1[n+1].bdir, tr1[n+1].bc}), 3);
    for (int k = 1; k <= 4; k++) chk("c1_cs", int'(tr1[n+k].cs), 1);
    next_cycle();

    // Read miss then read hit of chip 0 reg 8
    psg_ld = 1'b1; ld_c = 1'b0; ld_r = 4'h8; ld_v = 8'h0C;
    ref_regs[0][8] = 8'h0C;
    next_cycle();
    psg_ld = 1'b0;
    set_txn(0, 1'b0, 1'b0, 8, 0);
    req[0] = 1'b1;
    grant_one(g);
    n = last_n;
    req[0] = 1'b0;
    chk("rm_c3_bdirbc", int'({tr1[n+3].bdir, tr1[n+3].bc}), 1);
    next_cycle();
    single(0, 1'b0, 1'b0, 8, 0);
    next_cycle();
    chk("rd_held", int'(rd), 8'h0C);

    // Reset during DATA of a cache-hit write
    single(0, 1'b1, 1'b0, 5, 8'h21);
    set_txn(0, 1'b1, 1'b0, 5, 8'h22);
    req[0] = 1'b1;
    next_cycle();
    chk("abort_in_data", int'({bdir, bc}), 2);
    RESET = 1'b1;
    req[0] = 1'b0;
    next_cycle();
    RESET = 1'b0;
    chk("abort_bdir", int'(bdir), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'({ack0, ack1}), 0);
    mc_valid[0] = 1'b0; mc_valid[1] = 1'b0;
    m_last = 1;
    ref_regs[0][5] = 8'h22;
    repeat (3) next_cycle();
    set_txn(1, 1'b1, 1'b0, 5, 8'h23);
    req[1] = 1'b1;
    grant_one(g);
    n = last_n;
    req[1] = 1'b0;
    chk("post_rst_addr", int'({tr1[n+1].bdir, tr1[n+1].bc}), 3);
    next_cycle();

    // Both ports requesting continuously: alternating grants
    rand_txn(0); rand_txn(1);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grant_one(g);
      chk("tie_order", g, i % 2);
      rand_txn(g);
      if (i == 3) begin req[0] = 1'b0; req[1] = 1'b0; end
      next_cycle();
    end

    // Longer phase/gap instance: write miss
    we2 = 1'b1; cs2 = 1'b1; ra2 = 4'h9; wd2 = 8'hA5; req2 = 1'b1;
    n = cyc;
    repeat (2*P2 + 2*G2 + 1) next_cycle();
    req2 = 1'b0;
    next_cycle();
    for (int k = 1; k <= 2*P2 + 2*G2 + 1; k++) begin
      chk("p3_cs", int'(tr2[n+k].cs), 1);
      chk("p3_ack", int'(tr2[n+k].a0), int'(k == 2*P2 + 2*G2 + 1));
      if (k <= P2) begin
        chk("p3_addr", int'({tr2[n+k].bdir, tr2[n+k].bc}), 3);
        chk("p3_addr_do", int'(tr2[n+k].dout), 9);
      end else if (k <= P2 + G2 || (k > 2*P2 + G2 && k <= 2*P2 + 2*G2)) begin
        chk("p3_gap", int'({tr2[n+k].bdir, tr2[n+k].bc}), 0);
      end else if (k <= 2*P2 + G2) begin
        chk("p3_data", int'({tr2[n+k].bdir, tr2[n+k].bc}), 2);
        chk("p3_data_do", int'(tr2[n+k].dout), 8'hA5);
      end
    end
    chk("p3_ack_single", int'(tr2[n + 2*P2 + 2*G2 + 2].a0), 0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if (!req[0] && !req[1]) begin
        int mask;
        repeat ($urandom_range(0, 2)) next_cycle();
        mask = int'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++)
          if (mask[p]) begin rand_txn(p); req[p] = 1'b1; end
      end
      grant_one(g);
      if ($urandom_range(0, 1) == 1) rand_txn(g);
      else req[g] = 1'b0;
      if (!req[1-g] && $urandom_range(0, 3) == 0) begin
        rand_txn(1 - g);
        req[1-g] = 1'b1;
      end
      next_cycle();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (12) next_cycle();
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
